// File: rtl/bus_fabric_pkg.sv
// bus_fabric_pkg
//   Shared definitions for the bus fabric: access-sequencer state encoding,
//   wait-state and timeout counter widths, and the slave-index width helper.
package bus_fabric_pkg;

  localparam int unsigned WAITW = 4;  // per-slave minimum wait-state field width
  localparam int unsigned TOW   = 8;  // timeout counter width

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    DONE,
    FAULT
  } state_t;

  // Width of a slave index; a single-slave fabric still carries a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_fabric_decode.sv
// bus_fabric_decode
//   Combinational address decoder: compares the address against every slave's
//   base/mask window and returns the lowest matching slave index.
// Ports
//   address  in   AW   address to decode
//   hit      out  1    at least one window matches
//   index    out  IW   lowest matching slave index (0 when no hit)
module bus_fabric_decode
  import bus_fabric_pkg::*;
#(
  parameter int unsigned          NSLAVE = 8,
  parameter int unsigned          AW     = 32,
  parameter logic [NSLAVE*AW-1:0] BASE   = '0,
  parameter logic [NSLAVE*AW-1:0] MASK   = '0,
  parameter int unsigned          IW     = idx_width(NSLAVE)
) (
  input  logic [AW-1:0] address,
  output logic          hit,
  output logic [IW-1:0] index
);

  always_comb begin
    hit   = 1'b0;
    index = '0;
    // Ascending scan that stops updating at the first match gives lowest-index priority.
    for (int unsigned i = 0; i < NSLAVE; i++) begin
      if (!hit && ((address & MASK[i*AW +: AW]) == BASE[i*AW +: AW])) begin
        hit   = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// bus_fabric
//   Address decode and access sequencing between the CPU master port and
//   NSLAVE slaves. Each access pulses s_start, holds a one-hot select,
//   enforces the slave's minimum wait states, waits for s_ready, registers
//   the read data and strobes m_busfault on an unmapped address.
//   Optional build macro BUS_FABRIC_TIMEOUT_EN adds a WAIT-state timeout
//   (TIMEOUT cycles) that ends the access with a fault.
// Ports
//   clk, reset (async, active high)
//   m_address/m_read/m_write/m_byteenable   master request
//   m_readdata/m_waitrequest/m_busfault      master response
//   s_select/s_start/s_read/s_write          slave control
//   s_ready/s_readdata                       slave response (packed per slave)
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int unsigned             NSLAVE  = 8,
  parameter int unsigned             AW      = 32,
  parameter int unsigned             DW      = 32,
  parameter logic [NSLAVE*AW-1:0]    BASE    = '0,
  parameter logic [NSLAVE*AW-1:0]    MASK    = '0,
  parameter logic [NSLAVE*WAITW-1:0] WAITS   = '0,
  parameter int unsigned             TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW-1:0]        m_address,
  input  logic                 m_read,
  input  logic                 m_write,
  input  logic [DW/8-1:0]      m_byteenable,
  output logic [DW-1:0]        m_readdata,
  output logic                 m_waitrequest,
  output logic                 m_busfault,
  output logic [NSLAVE-1:0]    s_select,
  output logic                 s_start,
  output logic                 s_read,
  output logic                 s_write,
  input  logic [NSLAVE-1:0]    s_ready,
  input  logic [NSLAVE*DW-1:0] s_readdata
);

  localparam int unsigned    IW       = idx_width(NSLAVE);
  localparam logic [TOW-1:0] TO_LIMIT = TOW'(TIMEOUT);

  state_t           state, state_nx;
  logic [IW-1:0]    idx;
  logic [WAITW-1:0] wcnt;
  logic             dec_hit;
  logic [IW-1:0]    dec_idx;
  logic             req;
  logic             complete;
  logic             timeout;
  logic [DW-1:0]    rdata_sel;

  bus_fabric_decode #(
    .NSLAVE (NSLAVE),
    .AW     (AW),
    .BASE   (BASE),
    .MASK   (MASK),
    .IW     (IW)
  ) u_decode (
    .address (m_address),
    .hit     (dec_hit),
    .index   (dec_idx)
  );

  assign req       = m_read | m_write;
  assign rdata_sel = s_readdata[idx*DW +: DW];
  assign complete  = (wcnt >= WAITS[idx*WAITW +: WAITW]) && s_ready[idx];

  logic unused_be;
  assign unused_be = ^m_byteenable;

`ifdef BUS_FABRIC_TIMEOUT_EN
  logic [TOW-1:0] tcnt;

  assign timeout = (tcnt == TO_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (state == START) begin
      tcnt <= '0;
    end else if (state == WAIT) begin
      tcnt <= (tcnt == '1) ? tcnt : tcnt + 1'b1;
    end
  end
`else
  logic unused_to;
  assign unused_to = ^TO_LIMIT;
  assign timeout   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (req) state_nx = dec_hit ? START : FAULT;
      START: state_nx = WAIT;
      WAIT: begin
        if (complete)     state_nx = DONE;
        else if (timeout) state_nx = FAULT;
      end
      DONE:  state_nx = IDLE;
      FAULT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    s_start       = (state == START);
    s_write       = m_write && (|s_select);
    s_read        = m_read && !m_write && (|s_select);
    m_waitrequest = req && !(state inside {DONE, FAULT});
  end

  // Registered datapath: slave index, select, wait counter, read data, fault strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      s_select   <= '0;
      wcnt       <= '0;
      m_readdata <= '0;
      m_busfault <= 1'b0;
    end else begin
      m_busfault <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req && dec_hit) begin
            idx      <= dec_idx;
            s_select <= NSLAVE'(1) << dec_idx;
          end else if (req) begin
            m_readdata <= '0;
            m_busfault <= 1'b1;
          end
        end
        START: wcnt <= '0;
        WAIT: begin
          wcnt <= (wcnt == '1) ? wcnt : wcnt + 1'b1;
          if (complete) begin
            s_select <= '0;
            // A read withdrawn mid-access still finishes on the slave, but its data is dropped.
            if (m_read && !m_write) m_readdata <= rdata_sel;
          end else if (timeout) begin
            s_select   <= '0;
            m_readdata <= '0;
            m_busfault <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
module tb_bus_fabric;

  localparam int NS  = 4;
  localparam int TMO = 20;
  localparam logic [NS*32-1:0] BASE_P = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASK_P = {4{32'hF000_0000}};
  // Slave 3 becomes a catch-all window overlapping every other slave.
  localparam logic [NS*32-1:0] BASE_O = {32'h0000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASK_O = {32'h0000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
  localparam logic [NS*4-1:0]  WAITS_P = {4'd0, 4'd3, 4'd1, 4'd0};
`ifdef BUS_FABRIC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Minimum wait states by slave number, matching WAITS_P.
  int waits_tbl[NS] = '{0, 1, 3, 0};

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      m_address;
  logic             m_read, m_write;
  logic [3:0]       m_byteenable;
  logic [31:0]      m_readdata;
  logic             m_waitrequest, m_busfault;
  logic [NS-1:0]    s_select;
  logic             s_start, s_read, s_write;
  logic [NS-1:0]    s_ready;
  logic [NS*32-1:0] s_readdata;

  logic [31:0]      ov_address;
  logic             ov_read, ov_write;
  logic [31:0]      ov_readdata;
  logic             ov_waitrequest, ov_busfault;
  logic [NS-1:0]    ov_select;
  logic             ov_start, ov_sread, ov_swrite;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  bus_fabric #(
    .NSLAVE(NS), .AW(32), .DW(32), .BASE(BASE_P), .MASK(MASK_P),
    .WAITS(WAITS_P), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .m_address(m_address), .m_read(m_read),
    .m_write(m_write), .m_byteenable(m_byteenable), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest), .m_busfault(m_busfault), .s_select(s_select),
    .s_start(s_start), .s_read(s_read), .s_write(s_write), .s_ready(s_ready),
    .s_readdata(s_readdata)
  );

  bus_fabric #(
    .NSLAVE(NS), .AW(32), .DW(32), .BASE(BASE_O), .MASK(MASK_O),
    .WAITS(WAITS_P), .TIMEOUT(TMO)
  ) u_ovl (
    .clk(clk), .reset(reset), .m_address(ov_address), .m_read(ov_read),
    .m_write(ov_write), .m_byteenable(m_byteenable), .m_readdata(ov_readdata),
    .m_waitrequest(ov_waitrequest), .m_busfault(ov_busfault), .s_select(ov_select),
    .s_start(ov_start), .s_read(ov_sread), .s_write(ov_swrite), .s_ready(s_ready),
    .s_readdata(s_readdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One master access against the reference model. The slave's ready rises
  // d cycles after the request cycle (cycle 0 = request seen in IDLE).
  task automatic access(input logic [31:0] addr, input bit rd, input bit wr,
                        input int d, input logic [31:0] data);
    int sl, k, last;
    bit hit, is_rd, to_fault;
    logic [NS-1:0] sel_exp;
    sl       = int'(addr[31:28]);
    hit      = (sl < NS);
    is_rd    = rd && !wr;
    k        = 0;
    if (hit) k = (waits_tbl[sl] > d - 2) ? waits_tbl[sl] : d - 2;
    to_fault = !hit || (TO_EN && k > TMO);
    last     = !hit ? 1 : (to_fault ? 3 + TMO : 3 + k);
    sel_exp  = hit ? NS'(1 << sl) : '0;

    @(posedge clk); #1;
    m_address = addr;
    m_read    = rd;
    m_write   = wr;
    s_ready   = NS'($urandom);
    for (int i = 0; i < NS; i++) s_readdata[i*32 +: 32] = $urandom;
    if (hit) s_readdata[sl*32 +: 32] = data;

    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (hit) s_ready[sl] = (c >= d);
      @(negedge clk);
      chk("waitreq", 32'(m_waitrequest), 32'(c < last));
      if (c == last) begin
        exp_rd = to_fault ? 32'h0 : (is_rd ? data : exp_rd);
        chk("busfault", 32'(m_busfault), 32'(to_fault));
        chk("readdata", m_readdata, exp_rd);
        chk("select_end", 32'(s_select), 32'h0);
      end else begin
        chk("select", 32'(s_select), (hit && c >= 1) ? 32'(sel_exp) : 32'h0);
        chk("s_start", 32'(s_start), 32'(hit && c == 1));
        chk("s_write", 32'(s_write), 32'(hit && c >= 1 && wr));
        chk("s_read", 32'(s_read), 32'(hit && c >= 1 && is_rd));
        chk("busfault_low", 32'(m_busfault), 32'h0);
      end
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    m_read  = 1'b0;
    m_write = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Read through the overlapping-window instance and check which slave it picks.
  task automatic ovl_probe(input logic [31:0] addr, input logic [NS-1:0] exp_sel);
    bit done;
    bit flt;
    done = 1'b0;
    flt  = 1'b0;
    @(posedge clk); #1;
    ov_address = addr;
    ov_read    = 1'b1;
    s_ready    = '1;
    @(negedge clk);
    @(negedge clk);
    chk("ovl_select", 32'(ov_select), 32'(exp_sel));
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!ov_waitrequest) begin
        done = 1'b1;
        flt  = ov_busfault;
      end
    end
    chk("ovl_complete", 32'(done), 32'h1);
    chk("ovl_nofault", 32'(flt), 32'h0);
    @(posedge clk); #1;
    ov_read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, dat;
    int r;
    reset = 1'b1;
    m_address = '0; m_read = 1'b0; m_write = 1'b0; m_byteenable = 4'hF;
    ov_address = '0; ov_read = 1'b0; ov_write = 1'b0;
    s_ready = '0; s_readdata = '0;
    exp_rd = '0;

    // Reset state
    @(negedge clk);
    chk("rst_select", 32'(s_select), 32'h0);
    chk("rst_readdata", m_readdata, 32'h0);
    chk("rst_busfault", 32'(m_busfault), 32'h0);
    chk("rst_waitreq", 32'(m_waitrequest), 32'h0);
    chk("rst_start", 32'(s_start), 32'h0);
    reset = 1'b0;

    // Fastest read, then a back-to-back write to a slave with 3 wait states
    access(32'h0000_0010, 1'b1, 1'b0, 0, 32'hDEAD_BEEF);
    access(32'h2000_0004, 1'b0, 1'b1, 0, 32'h1234_5678);
    // Unmapped address
    access(32'h5000_0000, 1'b1, 1'b0, 0, 32'h0);
    // Read with and without a stalled slave
    access(32'h1000_0000, 1'b1, 1'b0, 0, 32'hA5A5_0001);
    access(32'h1000_0000, 1'b1, 1'b0, 40, 32'hC0DE_F00D);
    // Read and write together behave as a write
    access(32'h3000_0100, 1'b1, 1'b1, 1, 32'h0BAD_CAFE);
    idle(1);

    // Overlapping windows: lowest index wins, catch-all covers the rest
    ovl_probe(32'h1000_0000, 4'b0010);
    ovl_probe(32'h0000_0010, 4'b0001);
    ovl_probe(32'h5000_0000, 4'b1000);

    // Read withdrawn after START: slave cycle finishes, data is discarded
    @(posedge clk); #1;
    m_address = 32'h2000_0008; m_read = 1'b1; s_ready = '1;
    s_readdata[2*32 +: 32] = 32'h5555_AAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_read = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_select", 32'(s_select), 32'h4);
    chk("drop_waitreq", 32'(m_waitrequest), 32'h0);
    chk("drop_sread", 32'(s_read), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drop_select_end", 32'(s_select), 32'h0);
    chk("drop_readdata", m_readdata, exp_rd);
    chk("drop_busfault", 32'(m_busfault), 32'h0);

    // Reset in the middle of a WAIT
    @(posedge clk); #1;
    m_address = 32'h2000_0004; m_write = 1'b1; s_ready = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_select", 32'(s_select), 32'h4);
    #1 reset = 1'b1;
    #1;
    chk("async_select", 32'(s_select), 32'h0);
    chk("async_busfault", 32'(m_busfault), 32'h0);
    m_write = 1'b0;
    exp_rd  = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busfault", 32'(m_busfault), 32'h0);
    chk("post_rst_waitreq", 32'(m_waitrequest), 32'h0);
    chk("post_rst_readdata", m_readdata, 32'h0);
    access(32'h2000_0004, 1'b0, 1'b1, 0, 32'h0);

    // Randomized accesses, mapped and unmapped, with random ready delays
    for (int t = 0; t < 60; t++) begin
      a   = $urandom;
      a[31:28] = 4'($urandom_range(0, 5));
      dat = $urandom;
      r   = $urandom_range(1, 3);
      access(a, r[0], r[1], $urandom_range(0, 8), dat);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
